// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Conditions raw board push-buttons for the Game-of-Life top level. Each button
// goes through: polarity normalisation -> 2-flop synchroniser -> debouncer ->
// registered edge detector -> auto-repeat FSM. A held direction key therefore
// produces one fire pulse on press, one after REPEAT_DELAY cycles, then one
// every REPEAT_RATE cycles until release. Buttons are fully independent.
//
// Ports:
//   clk          system clock
//   rst          asynchronous reset, active low
//   btn_raw      raw asynchronous button pins
//   btn_level    debounced stable level, 1 = pressed
//   btn_press    one-cycle pulse when btn_level rises (aligned with btn_level)
//   btn_release  one-cycle pulse when btn_level falls (aligned with btn_level)
//   btn_fire     press pulse plus auto-repeat ticks (repeat-masked bits only)
//   fsm_state    debug view of the repeat FSM, 2 bits per button
//                (0 = IDLE, 1 = DELAY, 2 = REPEAT)
// -----------------------------------------------------------------------------
module button_conditioner #(
  parameter int               N_BTN           = 6,
  parameter int               DEBOUNCE_CYCLES = 500000,
  parameter int               REPEAT_DELAY    = 25000000,
  parameter int               REPEAT_RATE     = 5000000,
  parameter logic [N_BTN-1:0] REPEAT_MASK     = N_BTN'(6'b001111),
  parameter bit               ACTIVE_LOW      = 1'b0,
  parameter int               CNT_W           = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_BTN-1:0]     btn_raw,
  output logic [N_BTN-1:0]     btn_level,
  output logic [N_BTN-1:0]     btn_press,
  output logic [N_BTN-1:0]     btn_release,
  output logic [N_BTN-1:0]     btn_fire,
  output logic [2*N_BTN-1:0]   fsm_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rep_state_t;

  // Terminal counts; counters restart at 0 so a count of N needs N-1.
  localparam logic [CNT_W-1:0] D_TERM  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_TERM = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RR_TERM = CNT_W'(REPEAT_RATE - 1);

  // ---------------------------------------------------------------------------
  // Polarity normalisation and synchroniser. Inverting before the flops means
  // the all-zero reset value always reads as "released".
  // ---------------------------------------------------------------------------
  logic [N_BTN-1:0] norm;
  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] sync2;

  assign norm = ACTIVE_LOW ? ~btn_raw : btn_raw;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= norm;
      sync2 <= sync1;
    end
  end

  // ---------------------------------------------------------------------------
  // Debouncer. The counter runs only while the synchronised input disagrees
  // with the stable level; any agreement clears it. rise/fall mark the cycle
  // in which the stable level is about to change.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] dcnt_q [N_BTN];
  logic [CNT_W-1:0] dcnt_d [N_BTN];
  logic [N_BTN-1:0] level_d;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] fall;

  always_comb begin
    level_d = btn_level;
    rise    = '0;
    fall    = '0;
    for (int i = 0; i < N_BTN; i++) begin
      dcnt_d[i] = '0;
      if (sync2[i] != btn_level[i]) begin
        if (dcnt_q[i] == D_TERM) begin
          level_d[i] = sync2[i];
          rise[i]    = sync2[i];
          fall[i]    = ~sync2[i];
        end else begin
          dcnt_d[i] = dcnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Press/release are registered alongside the level so all three line up.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_BTN; i++) dcnt_q[i] <= '0;
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) dcnt_q[i] <= dcnt_d[i];
      btn_level   <= level_d;
      btn_press   <= rise;
      btn_release <= fall;
    end
  end

  // ---------------------------------------------------------------------------
  // Auto-repeat FSM: state register / next-state / outputs.
  // ---------------------------------------------------------------------------
  rep_state_t       state_q [N_BTN];
  rep_state_t       state_d [N_BTN];
  logic [CNT_W-1:0] rcnt_q  [N_BTN];
  logic [CNT_W-1:0] rcnt_d  [N_BTN];
  logic [N_BTN-1:0] fire_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= IDLE;
        rcnt_q[i]  <= '0;
      end
      btn_fire <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= state_d[i];
        rcnt_q[i]  <= rcnt_d[i];
      end
      btn_fire <= fire_d;
    end
  end

  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        IDLE:    if (rise[i] && REPEAT_MASK[i]) state_d[i] = DELAY;
        DELAY:   if (fall[i]) state_d[i] = IDLE;
                 else if (rcnt_q[i] == RD_TERM) state_d[i] = REPEAT;
        REPEAT:  if (fall[i]) state_d[i] = IDLE;
        default: state_d[i] = IDLE;
      endcase
    end
  end

  // A release always wins over a coinciding terminal count: no pulse then.
  always_comb begin
    fire_d = '0;
    for (int i = 0; i < N_BTN; i++) begin
      rcnt_d[i] = '0;
      case (state_q[i])
        IDLE: fire_d[i] = rise[i];
        DELAY: begin
          if (!fall[i]) begin
            if (rcnt_q[i] == RD_TERM) fire_d[i] = 1'b1;
            else rcnt_d[i] = rcnt_q[i] + CNT_W'(1);
          end
        end
        REPEAT: begin
          if (!fall[i]) begin
            if (rcnt_q[i] == RR_TERM) fire_d[i] = 1'b1;
            else rcnt_d[i] = rcnt_q[i] + CNT_W'(1);
          end
        end
        default: fire_d[i] = 1'b0;
      endcase
    end
  end

  always_comb begin
    fsm_state = '0;
    for (int i = 0; i < N_BTN; i++) fsm_state[2*i +: 2] = state_q[i];
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Conditions raw board push-buttons for the Game-of-Life top level.
- Per button: synchroniser, debouncer, edge detector and optional auto-repeat.
- Sits directly upstream of the freeze-mode toggle and the cursor-movement logic.
- Outputs clean single-cycle press pulses and auto-repeating "fire" pulses, so a held direction key steps the cursor at a controlled rate.

Parameters:
- N_BTN, 6: number of buttons. Bits [3:0] are move up/down/left/right, [4] is freeze, [5] is cell toggle.
- DEBOUNCE_CYCLES, 500000: consecutive clk cycles the synchronised input must hold a new value before the stable level changes (10 ms @ 50 MHz).
- REPEAT_DELAY, 25000000: held cycles after a press before the first repeat pulse (0.5 s).
- REPEAT_RATE, 5000000: cycles between subsequent repeat pulses (0.1 s).
- REPEAT_MASK, 6'b001111: bit i=1 enables auto-repeat for button i.
- ACTIVE_LOW, 0: 1 means the raw inputs are inverted before synchronisation (pressed = 0).
- CNT_W, 32: width of the per-button counters. Must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE).

Ports:
- clk  input  1  system clock (50 MHz board clock)
- rst  input  1  asynchronous, active-low reset
- btn_raw  input  N_BTN  raw asynchronous button pins
- btn_level  output  N_BTN  debounced stable level, 1 = pressed
- btn_press  output  N_BTN  one-cycle pulse on debounced rising edge
- btn_release  output  N_BTN  one-cycle pulse on debounced falling edge
- btn_fire  output  N_BTN  one-cycle pulse on press, plus each auto-repeat tick (repeat-masked buttons only)

Behaviour:
- Reset (rst=0, asynchronous) clears everything to 0: synchroniser flops, debounce counters, repeat counters, FSM state (IDLE) and all four outputs.
  - Raw polarity is normalised before the sync flops, so reset is equivalent to "released".
- Synchroniser: two flops per bit after the ACTIVE_LOW inversion; s = second flop.
- Debounce, per bit, with counter dcnt:
  - If s == btn_level: dcnt <= 0.
  - Else: dcnt <= dcnt+1, and when dcnt == DEBOUNCE_CYCLES-1, btn_level <= s and dcnt <= 0.
  - Any bounce back to the old level before the threshold clears dcnt.
- Latency: the raw edge is first sampled at edge k; btn_level changes at edge k+1+DEBOUNCE_CYCLES.
- Edge pulses:
  - btn_press is high exactly in the cycle btn_level goes 0->1.
  - btn_release is high exactly in the cycle btn_level goes 1->0.
  - Both are registered, so they align with btn_level.
- Repeat FSM, per bit, with counter rcnt. States IDLE, DELAY, REPEAT:
  - IDLE: on a debounced rise, btn_fire=1 for that cycle. If REPEAT_MASK[i], go to DELAY with rcnt=0; else stay IDLE.
  - DELAY: rcnt increments each cycle. When rcnt == REPEAT_DELAY-1: btn_fire=1, rcnt=0, go to REPEAT.
  - REPEAT: rcnt increments. When rcnt == REPEAT_RATE-1: btn_fire=1, rcnt=0, stay in REPEAT.
  - Debounced fall in any state: go to IDLE, rcnt=0, no fire pulse that cycle.
  - If a fall coincides with a repeat terminal count, the fall wins and no pulse is issued.
- Non-masked buttons: btn_fire equals btn_press.
- Buttons are fully independent. Simultaneous presses on several bits produce simultaneous pulses; there is no priority or arbitration.
- Button held across reset deassertion: treated as a new press. After DEBOUNCE_CYCLES+1 cycles, btn_level rises with btn_press and btn_fire pulses.
- Reset asserted mid-debounce or mid-repeat: state is lost immediately, with no spurious release pulse.
- Counters never wrap in normal operation because the terminal compare precedes overflow. CNT_W below the required width is a configuration error.
- Minimum legal value of DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_RATE is 1.

Test Plan (bench params: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, REPEAT_MASK=6'b001111, ACTIVE_LOW=0):
- Clean press: btn_raw[0] 0->1 and held 30 cycles, then released -> btn_level[0] rises 5 cycles after first sampled high. Same cycle: btn_press[0]=1 and btn_fire[0]=1 for 1 cycle. btn_fire[0] repeats 10 cycles later, then every 3 cycles. On release, btn_release[0] pulses 5 cycles after the falling sample, with no fire pulse.
- Bounce rejection: btn_raw[1] toggles high 3 cycles / low 1 cycle five times, then stays high -> no btn_press until 4 consecutive synchronised highs. Exactly one press pulse results.
- Non-repeat button: btn_raw[4] held 40 cycles -> exactly one btn_press[4] and one btn_fire[4]. No further fire pulses; one btn_release[4] after release.
- Simultaneous buttons: btn_raw[2] and btn_raw[5] rise in the same cycle -> btn_press[2] and btn_press[5] pulse in the same cycle. Only bit 2 auto-repeats.
- Reset mid-repeat: bit 0 in REPEAT, assert rst=0 for 2 cycles while still held -> all outputs 0 immediately, no release pulse. After deassert, a fresh press (level, press and fire pulses) appears 5 cycles later.
- ACTIVE_LOW=1 variant: btn_raw idle at all-ones gives no pulses after reset. Driving bit 3 low for 8 cycles -> one press pulse and one release pulse.
